// File: rtl/debounce_pkg.sv
// Shared state encoding and board-clock defaults for the push-button debouncer.
// 500000 cycles at 50 MHz gives a 10 ms acceptance window.
package debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_WIDTH       = 20;

  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; 2-cycle latency, no backpressure.
// Reusable for any async control input landing in the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button into a registered level plus 1-cycle press/release pulses; no backpressure.
// Latency 2+DEBOUNCE_CYCLES edges; release pulse built only with DEBOUNCE_RELEASE_PULSE_EN.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 w_s2;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_level;
  logic                 w_level_nxt;
  logic                 r_press;
  logic                 w_press_nxt;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic                 r_release;
  logic                 w_release_nxt;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (btn),
    .q     (w_s2)
  );

  // A flip of s2 always takes priority over the terminal count, so a glitch
  // on the last counted cycle still rejects the transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_press_nxt = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    w_release_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE_LOW: begin
        if (w_s2) begin
          w_state_nxt = ST_WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!w_s2) begin
          w_state_nxt = ST_IDLE_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HIGH;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!w_s2) begin
          w_state_nxt = ST_WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (w_s2) begin
          w_state_nxt = ST_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE_LOW;
          w_level_nxt = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
          w_release_nxt = 1'b1;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE_LOW;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_press <= w_press_nxt;
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_release <= 1'b0;
    end else begin
      r_release <= w_release_nxt;
    end
  end

  assign release_pulse = r_release;
`else
  assign release_pulse = 1'b0;
`endif

  assign level       = r_level;
  assign press_pulse = r_press;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
// Outputs are sampled 1 ns after each rising edge; inputs change at that same point.
module tb_button_debouncer;

  logic clk;
  logic clr_n;
  logic btn;
  logic level;
  logic press_pulse;
  logic release_pulse;

  int n_checks;
  int n_fail;
  int both_cnt;

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  localparam int REL_EXP = 1;
`else
  localparam int REL_EXP = 0;
`endif

  button_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (3)
  ) dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .btn           (btn),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n edges, tallying pulses; p_first is the 1-based edge of the first press.
  task automatic watch(input int n, output int p_cnt, output int p_first,
                       output int r_cnt, output int r_first);
    p_cnt = 0; p_first = 0; r_cnt = 0; r_first = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse === 1'b1) begin
        p_cnt++;
        if (p_first == 0) p_first = i;
      end
      if (release_pulse === 1'b1) begin
        r_cnt++;
        if (r_first == 0) r_first = i;
      end
      if (press_pulse === 1'b1 && release_pulse === 1'b1) both_cnt++;
    end
  endtask

  task automatic test_reset();
    int pc, pf, rc, rf;
    clr_n = 1'b0;
    btn   = 1'b1;
    #1;
    n_checks++;
    if ({level, press_pulse, release_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_async_t0: got %b expected 000", {level, press_pulse, release_pulse});
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({level, press_pulse, release_pulse} !== 3'b000) begin
        n_fail++; $display("FAIL reset_hold_cycle%0d: got %b expected 000", c, {level, press_pulse, release_pulse});
      end
    end
    clr_n = 1'b1;
    watch(2, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0) begin
      n_fail++; $display("FAIL reset_no_early_press: got %0d pulses expected 0", pc);
    end
    // Only two samples of btn=1 after release: rejected as a bounce.
    btn = 1'b0;
    watch(10, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0 || level !== 1'b0) begin
      n_fail++; $display("FAIL reset_short_high: got %0d pulses level %b expected 0 pulses level 0", pc, level);
    end
  endtask

  task automatic test_press();
    int pc, pf, rc, rf;
    btn = 1'b1;
    watch(6, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0 || level !== 1'b0) begin
      n_fail++; $display("FAIL press_before_k6: got %0d pulses level %b expected 0 pulses level 0", pc, level);
    end
    watch(1, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 1 || level !== 1'b1) begin
      n_fail++; $display("FAIL press_at_k6: got %0d pulses level %b expected 1 pulse level 1", pc, level);
    end
    watch(5, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0 || level !== 1'b1) begin
      n_fail++; $display("FAIL press_after_k6: got %0d pulses level %b expected 0 pulses level 1", pc, level);
    end
  endtask

  task automatic test_release();
    int pc, pf, rc, rf;
    btn = 1'b0;
    watch(6, pc, pf, rc, rf);
    n_checks++;
    if (rc !== 0 || level !== 1'b1) begin
      n_fail++; $display("FAIL release_before_k6: got %0d pulses level %b expected 0 pulses level 1", rc, level);
    end
    watch(1, pc, pf, rc, rf);
    n_checks++;
    if (rc !== REL_EXP || level !== 1'b0 || pc !== 0) begin
      n_fail++; $display("FAIL release_at_k6: got rel %0d press %0d level %b expected rel %0d press 0 level 0", rc, pc, level, REL_EXP);
    end
    watch(5, pc, pf, rc, rf);
    n_checks++;
    if (rc !== 0 || pc !== 0 || level !== 1'b0) begin
      n_fail++; $display("FAIL release_after_k6: got rel %0d press %0d level %b expected 0 0 0", rc, pc, level);
    end
  endtask

  task automatic test_bounce();
    int pc, pf, rc, rf;
    btn = 1'b1;
    watch(3, pc, pf, rc, rf);
    btn = 1'b0;
    watch(12, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0 || level !== 1'b0) begin
      n_fail++; $display("FAIL bounce_3cyc: got %0d pulses level %b expected 0 pulses level 0", pc, level);
    end
  endtask

  task automatic test_final_cycle_glitch();
    int pc, pf, rc, rf, tot_p;
    // Four samples high: s2 drops exactly when the count reaches its limit.
    btn = 1'b1;
    watch(4, pc, pf, rc, rf);
    tot_p = pc;
    btn = 1'b0;
    watch(12, pc, pf, rc, rf);
    tot_p += pc;
    n_checks++;
    if (tot_p !== 0 || level !== 1'b0) begin
      n_fail++; $display("FAIL glitch_last_count: got %0d pulses level %b expected 0 pulses level 0", tot_p, level);
    end
    // Five samples high is the shortest run that is accepted.
    btn = 1'b1;
    watch(5, pc, pf, rc, rf);
    tot_p = pc;
    btn = 1'b0;
    watch(2, pc, pf, rc, rf);
    n_checks++;
    if (tot_p !== 0 || pc !== 1 || pf !== 2) begin
      n_fail++; $display("FAIL five_high_press: got %0d+%0d pulses at step %0d expected 0+1 at step 2", tot_p, pc, pf);
    end
    watch(20, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0 || rc !== REL_EXP || level !== 1'b0) begin
      n_fail++; $display("FAIL five_high_release: got press %0d rel %0d level %b expected 0 %0d 0", pc, rc, level, REL_EXP);
    end
  endtask

  task automatic test_bounce_train();
    int pc, pf, rc, rf, p_tot, p_step;
    logic [0:9] train;
    train  = 10'b1011011111;
    p_tot  = 0;
    p_step = 0;
    for (int i = 1; i <= 16; i++) begin
      btn = (i <= 10) ? train[i-1] : 1'b1;
      watch(1, pc, pf, rc, rf);
      if (pc != 0 && p_step == 0) p_step = i;
      p_tot += pc;
    end
    n_checks++;
    if (p_tot !== 1 || p_step !== 12) begin
      n_fail++; $display("FAIL bounce_train: got %0d pulses first at step %0d expected 1 at step 12", p_tot, p_step);
    end
    btn = 1'b0;
    watch(12, pc, pf, rc, rf);
    n_checks++;
    if (level !== 1'b0 || rc !== REL_EXP) begin
      n_fail++; $display("FAIL bounce_train_release: got level %b rel %0d expected 0 %0d", level, rc, REL_EXP);
    end
  endtask

  task automatic test_abort();
    int pc, pf, rc, rf;
    btn = 1'b1;
    watch(5, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0) begin
      n_fail++; $display("FAIL abort_pre: got %0d pulses expected 0", pc);
    end
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({level, press_pulse, release_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL abort_async: got %b expected 000", {level, press_pulse, release_pulse});
    end
    #2;
    clr_n = 1'b1;
    watch(6, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0 || level !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_early: got %0d pulses level %b expected 0 pulses level 0", pc, level);
    end
    watch(1, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 1 || level !== 1'b1) begin
      n_fail++; $display("FAIL abort_full_recount: got %0d pulses level %b expected 1 pulse level 1", pc, level);
    end
    // Reset from HIGH must drop level without waiting for an edge.
    clr_n = 1'b0;
    #1;
    n_checks++;
    if (level !== 1'b0) begin
      n_fail++; $display("FAIL high_async_clear: got level %b expected 0", level);
    end
    @(posedge clk);
    #1;
    btn   = 1'b0;
    clr_n = 1'b1;
    watch(10, pc, pf, rc, rf);
    n_checks++;
    if (pc !== 0 || rc !== 0 || level !== 1'b0) begin
      n_fail++; $display("FAIL post_clear_idle: got press %0d rel %0d level %b expected 0 0 0", pc, rc, level);
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++; $display("FAIL pulses_exclusive: got %0d overlapping cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    both_cnt = 0;
    clr_n    = 1'b0;
    btn      = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_final_cycle_glitch();
    test_bounce_train();
    test_abort();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
